// File: rtl/bp_be_pkg.sv
// Shared backend writeback types: arbiter state enum, writeback packet layout and width macro.
`define BP_BE_WB_PKT_WIDTH(addr_w, data_w) (2 + (addr_w) + (data_w))

package bp_be_pkg;

  localparam int unsigned dword_width_gp    = 64;
  localparam int unsigned reg_addr_width_gp = 5;

  typedef enum logic {
    e_wb_normal = 1'b0,
    e_wb_drain  = 1'b1
  } bp_be_wb_arb_state_e;

  typedef struct packed {
    logic                         rd_w_v;
    logic                         fp_not_int;
    logic [reg_addr_width_gp-1:0] rd_addr;
    logic [dword_width_gp-1:0]    rd_data;
  } bp_be_wb_pkt_s;

  localparam int unsigned wb_pkt_width_gp = $bits(bp_be_wb_pkt_s);

endpackage

// File: rtl/bp_be_wb_rr_picker.sv
// Round-robin picker: first valid requester at or after the pointer, wrapping.
module bp_be_wb_rr_picker
  import bp_be_pkg::*;
#(
  parameter  int unsigned num_p        = 3,
  localparam int unsigned ptr_width_lp = $clog2(num_p)
) (
  input  logic [num_p-1:0]        v_i,
  input  logic [ptr_width_lp-1:0] ptr_i,
  output logic [num_p-1:0]        grant_o,
  output logic [ptr_width_lp-1:0] idx_o,
  output logic                    v_o
);

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    v_o     = 1'b0;
    for (int unsigned off = 0; off < num_p; off++) begin
      if (!v_o && v_i[(32'(ptr_i) + off) % num_p]) begin
        v_o   = 1'b1;
        idx_o = ptr_width_lp'((32'(ptr_i) + off) % num_p);
      end
    end
    if (v_o) grant_o[idx_o] = 1'b1;
  end

endmodule

// File: rtl/bp_be_wb_arbiter.sv
// Regfile write-port arbiter: primary pipe first, long-latency requesters round-robin,
// with a starvation stall. Optional BP_BE_WB_ARB_STATS_EN enables the denied-cycle counter.
module bp_be_wb_arbiter
  import bp_be_pkg::*;
#(
  parameter  int unsigned num_ll_p         = 3,
  parameter  int unsigned dword_width_p    = 64,
  parameter  int unsigned reg_addr_width_p = 5,
  parameter  int unsigned starve_limit_p   = 8,
  localparam int unsigned wb_pkt_width_lp  = 2 + reg_addr_width_p + dword_width_p
) (
  input  logic                              clk_i,
  input  logic                              reset_i,
  input  logic [wb_pkt_width_lp-1:0]        pipe_wb_pkt_i,
  input  logic [num_ll_p-1:0]               ll_v_i,
  input  logic [num_ll_p*wb_pkt_width_lp-1:0] ll_pkt_i,
  output logic [num_ll_p-1:0]               ll_yumi_o,
  output logic [wb_pkt_width_lp-1:0]        wb_pkt_o,
  output logic                              pipe_stall_o,
  output logic [31:0]                       ll_stall_cnt_o
);

  localparam int unsigned ptr_width_lp = $clog2(num_ll_p);
  localparam int unsigned cnt_width_lp = $clog2(starve_limit_p + 1);
  localparam int unsigned v_bit_lp     = wb_pkt_width_lp - 1;
  localparam int unsigned fp_bit_lp    = wb_pkt_width_lp - 2;

  bp_be_wb_arb_state_e         state_q, state_d;
  logic [ptr_width_lp-1:0]     rr_ptr_q, rr_ptr_d;
  logic [cnt_width_lp-1:0]     starve_cnt_q, starve_cnt_d;
  logic [wb_pkt_width_lp-1:0]  wb_pkt_q, wb_pkt_d;
  logic                        pipe_stall_q, pipe_stall_d;

  logic [num_ll_p-1:0]         win_grant;
  logic [ptr_width_lp-1:0]     win_idx;
  logic                        win_v;
  logic                        pipe_v;
  logic                        ll_sel;
  logic                        sel_v;
  logic                        denied;
  logic                        x0_dest;
  logic [wb_pkt_width_lp-1:0]  sel_pkt;

  assign pipe_v = pipe_wb_pkt_i[v_bit_lp];

  bp_be_wb_rr_picker #(.num_p(num_ll_p)) picker (
    .v_i     (ll_v_i),
    .ptr_i   (rr_ptr_q),
    .grant_o (win_grant),
    .idx_o   (win_idx),
    .v_o     (win_v)
  );

  // Selection; nothing is accepted while reset is held so pending requests survive it.
  always_comb begin
    ll_yumi_o = '0;
    sel_pkt   = '0;
    sel_v     = 1'b0;
    ll_sel    = 1'b0;
    if (!reset_i) begin
      if (pipe_v) begin
        sel_pkt = pipe_wb_pkt_i;
        sel_v   = 1'b1;
      end else if (win_v) begin
        ll_sel    = 1'b1;
        ll_yumi_o = win_grant;
        sel_pkt   = ll_pkt_i[32'(win_idx) * wb_pkt_width_lp +: wb_pkt_width_lp];
        sel_v     = 1'b1;
      end
    end
  end

  assign denied = (|ll_v_i) && !ll_sel;

  // Next-state: output packet, pointer, starvation counter and drain FSM.
  always_comb begin
    x0_dest      = !sel_pkt[fp_bit_lp] && (sel_pkt[dword_width_p +: reg_addr_width_p] == '0);
    wb_pkt_d     = sel_pkt;
    wb_pkt_d[v_bit_lp] = sel_v && sel_pkt[v_bit_lp] && !x0_dest;
    rr_ptr_d     = rr_ptr_q;
    starve_cnt_d = '0;
    state_d      = state_q;
    pipe_stall_d = pipe_stall_q;

    if (ll_sel) begin
      rr_ptr_d = (win_idx == ptr_width_lp'(num_ll_p - 1)) ? '0
                                                           : ptr_width_lp'(32'(win_idx) + 32'd1);
    end

    if (denied) begin
      starve_cnt_d = (starve_cnt_q == cnt_width_lp'(starve_limit_p))
                   ? starve_cnt_q : starve_cnt_q + cnt_width_lp'(1);
    end

    case (state_q)
      e_wb_normal: begin
        if (denied && starve_cnt_d == cnt_width_lp'(starve_limit_p - 1)) begin
          state_d      = e_wb_drain;
          pipe_stall_d = 1'b1;
        end
      end
      e_wb_drain: begin
        // A pipe write here is an upstream bug; the pipe still wins and we keep draining.
        if (!pipe_v && (ll_sel || ll_v_i == '0)) begin
          state_d      = e_wb_normal;
          pipe_stall_d = 1'b0;
        end
      end
      default: begin
        state_d      = e_wb_normal;
        pipe_stall_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= e_wb_normal;
      rr_ptr_q     <= '0;
      starve_cnt_q <= '0;
      wb_pkt_q     <= '0;
      pipe_stall_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      starve_cnt_q <= starve_cnt_d;
      wb_pkt_q     <= wb_pkt_d;
      pipe_stall_q <= pipe_stall_d;
    end
  end

  assign wb_pkt_o     = wb_pkt_q;
  assign pipe_stall_o = pipe_stall_q;

`ifdef BP_BE_WB_ARB_STATS_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (denied && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) stall_cnt_q <= '0;
    else         stall_cnt_q <= stall_cnt_d;
  end

  assign ll_stall_cnt_o = stall_cnt_q;
`else
  assign ll_stall_cnt_o = '0;
`endif

  a_no_pipe_write_while_stalled: assert property (
    @(posedge clk_i) disable iff (reset_i) !(pipe_stall_q && pipe_v));

endmodule

// File: tb/tb_bp_be_wb_arbiter.sv
// Self-checking bench for bp_be_wb_arbiter (default parameters) with a reference-model scoreboard.
module tb_bp_be_wb_arbiter;
  import bp_be_pkg::*;

  localparam int unsigned W   = 2 + 5 + 64;
  localparam int unsigned N   = 3;
  localparam int unsigned LIM = 8;
`ifdef BP_BE_WB_ARB_STATS_EN
  localparam bit stats_en_lp = 1'b1;
`else
  localparam bit stats_en_lp = 1'b0;
`endif

  typedef struct {
    logic [W-1:0] pkt;
    logic [N-1:0] yumi;
    logic         stall;
    logic [31:0]  stats;
  } exp_t;

  logic           clk = 1'b0;
  logic           reset_i;
  logic [W-1:0]   pipe_wb_pkt_i;
  logic [N-1:0]   ll_v_i;
  logic [N*W-1:0] ll_pkt_i;
  logic [N-1:0]   ll_yumi_o;
  logic [W-1:0]   wb_pkt_o;
  logic           pipe_stall_o;
  logic [31:0]    ll_stall_cnt_o;

  int checks   = 0;
  int failures = 0;
  exp_t sb[$];
  logic [N-1:0] yumi_seen;

  int          m_ptr;
  int          m_cnt;
  bit          m_drain;
  int unsigned m_stats;

  bp_be_wb_arbiter dut (
    .clk_i          (clk),
    .reset_i        (reset_i),
    .pipe_wb_pkt_i  (pipe_wb_pkt_i),
    .ll_v_i         (ll_v_i),
    .ll_pkt_i       (ll_pkt_i),
    .ll_yumi_o      (ll_yumi_o),
    .wb_pkt_o       (wb_pkt_o),
    .pipe_stall_o   (pipe_stall_o),
    .ll_stall_cnt_o (ll_stall_cnt_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  function automatic logic [W-1:0] mk(input logic v, input logic fp, input logic [4:0] a,
                                      input logic [63:0] d);
    bp_be_wb_pkt_s s;
    s.rd_w_v = v; s.fp_not_int = fp; s.rd_addr = a; s.rd_data = d;
    return s;
  endfunction

  // Drives one cycle, captures same-cycle yumi, pushes model expectations, returns after the edge.
  task automatic drive(input logic rst, input logic [W-1:0] pp, input logic [N-1:0] v);
    exp_t          e;
    bp_be_wb_pkt_s s;
    logic          sel;
    logic          den;
    int            w;
    @(negedge clk);
    reset_i = rst; pipe_wb_pkt_i = pp; ll_v_i = v;
    #1;
    yumi_seen = ll_yumi_o;
    e.yumi = '0; s = '0; sel = 1'b0;
    if (rst) begin
      m_ptr = 0; m_cnt = 0; m_drain = 1'b0; m_stats = 0;
    end else begin
      if (pp[W-1]) begin
        s = pp; sel = 1'b1;
      end else if (v != '0) begin
        w = m_ptr;
        while (!v[w]) w = (w + 1) % N;
        e.yumi = N'(1 << w);
        s = ll_pkt_i[w*W +: W];
        sel = 1'b1;
        m_ptr = (w + 1) % N;
      end
      if (sel && !s.fp_not_int && s.rd_addr == 5'd0) s.rd_w_v = 1'b0;
      den = (v != '0) && (e.yumi == '0);
      if (den) begin
        m_cnt = (m_cnt < LIM) ? m_cnt + 1 : LIM;
        m_stats++;
      end else m_cnt = 0;
      if (!m_drain) begin
        if (den && m_cnt == LIM - 1) m_drain = 1'b1;
      end else if (!pp[W-1] && (e.yumi != '0 || v == '0)) m_drain = 1'b0;
    end
    e.pkt   = s;
    e.stall = m_drain;
    e.stats = stats_en_lp ? 32'(m_stats) : 32'd0;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    exp_t e;
    drive(1'b1, '0, '0);
    e = sb.pop_front();
  endtask

  task automatic run_to_drain(input logic [N-1:0] v, output bit ok);
    exp_t e;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      drive(1'b0, mk(1'b1, 1'b0, 5'd3, 64'(i)), v);
      e = sb.pop_front();
      ok = (pipe_stall_o === 1'b1);
    end
  endtask

  task automatic test_reset();
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, mk(1'b1, 1'b0, 5'd4, 64'h1), 3'b111);
      e = sb.pop_front();
      checks++; if (yumi_seen !== 3'b000) begin failures++; $display("FAIL reset_yumi got=%b exp=000", yumi_seen); end
      checks++; if (wb_pkt_o !== e.pkt || wb_pkt_o !== '0) begin failures++; $display("FAIL reset_wb got=%h exp=0", wb_pkt_o); end
      checks++; if (pipe_stall_o !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", pipe_stall_o); end
      checks++; if (ll_stall_cnt_o !== 32'd0) begin failures++; $display("FAIL reset_stats got=%0d exp=0", ll_stall_cnt_o); end
    end
  endtask

  task automatic test_pipe_priority();
    exp_t         e;
    logic [W-1:0] pp [3];
    logic [W-1:0] want [3];
    pp[0] = mk(1'b1, 1'b0, 5'd5, 64'hAA);   want[0] = mk(1'b1, 1'b0, 5'd5, 64'hAA);
    pp[1] = mk(1'b1, 1'b1, 5'd0, 64'h55);   want[1] = mk(1'b1, 1'b1, 5'd0, 64'h55);
    pp[2] = mk(1'b1, 1'b0, 5'd0, 64'h77);   want[2] = mk(1'b0, 1'b0, 5'd0, 64'h77);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, pp[i], 3'b111);
      e = sb.pop_front();
      checks++; if (yumi_seen !== 3'b000) begin failures++; $display("FAIL prio_yumi[%0d] got=%b exp=000", i, yumi_seen); end
      checks++; if (wb_pkt_o !== want[i]) begin failures++; $display("FAIL prio_wb[%0d] got=%h exp=%h", i, wb_pkt_o, want[i]); end
      checks++; if (wb_pkt_o !== e.pkt) begin failures++; $display("FAIL prio_sb[%0d] got=%h exp=%h", i, wb_pkt_o, e.pkt); end
    end
  endtask

  task automatic test_round_robin();
    exp_t         e;
    logic [N-1:0] v    [7] = '{3'b111, 3'b111, 3'b111, 3'b111, 3'b101, 3'b101, 3'b110};
    logic [N-1:0] want [7] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b100, 3'b001, 3'b010};
    do_reset();
    for (int i = 0; i < 7; i++) begin
      drive(1'b0, '0, v[i]);
      e = sb.pop_front();
      checks++; if (yumi_seen !== want[i]) begin failures++; $display("FAIL rr_yumi[%0d] got=%b exp=%b", i, yumi_seen, want[i]); end
      checks++; if (wb_pkt_o !== e.pkt) begin failures++; $display("FAIL rr_wb[%0d] got=%h exp=%h", i, wb_pkt_o, e.pkt); end
      checks++; if (pipe_stall_o !== 1'b0) begin failures++; $display("FAIL rr_stall[%0d] got=%b exp=0", i, pipe_stall_o); end
    end
  endtask

  task automatic test_starve();
    exp_t         e;
    logic [W-1:0] pp;
    logic [31:0]  want_stats;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      pp = (pipe_stall_o === 1'b1) ? '0 : mk(1'b1, 1'b0, 5'd9, 64'(i));
      drive(1'b0, pp, 3'b010);
      e = sb.pop_front();
      want_stats = stats_en_lp ? ((i < 7) ? 32'(i + 1) : 32'(i)) : 32'd0;
      checks++; if (yumi_seen !== ((i == 7) ? 3'b010 : 3'b000)) begin failures++; $display("FAIL starve_yumi[%0d] got=%b", i, yumi_seen); end
      checks++; if (pipe_stall_o !== (i == 6)) begin failures++; $display("FAIL starve_stall[%0d] got=%b exp=%b", i, pipe_stall_o, (i == 6)); end
      checks++; if (wb_pkt_o !== e.pkt) begin failures++; $display("FAIL starve_wb[%0d] got=%h exp=%h", i, wb_pkt_o, e.pkt); end
      checks++; if (ll_stall_cnt_o !== want_stats || ll_stall_cnt_o !== e.stats) begin failures++; $display("FAIL starve_stats[%0d] got=%0d exp=%0d", i, ll_stall_cnt_o, want_stats); end
    end
  endtask

  task automatic test_x0_filter();
    exp_t e;
    do_reset();
    for (int i = 0; i < 2; i++) begin
      ll_pkt_i[0 +: W] = mk(1'b1, 1'(i), 5'd0, 64'hDEAD);
      drive(1'b0, '0, 3'b001);
      e = sb.pop_front();
      checks++; if (yumi_seen !== 3'b001) begin failures++; $display("FAIL x0_yumi[%0d] got=%b exp=001", i, yumi_seen); end
      checks++; if (wb_pkt_o[W-1] !== 1'(i)) begin failures++; $display("FAIL x0_rd_w_v[%0d] got=%b exp=%0d", i, wb_pkt_o[W-1], i); end
      checks++; if (wb_pkt_o !== e.pkt) begin failures++; $display("FAIL x0_wb[%0d] got=%h exp=%h", i, wb_pkt_o, e.pkt); end
    end
    ll_pkt_i[0 +: W] = mk(1'b1, 1'b0, 5'd1, 64'h100);
  endtask

  task automatic test_reset_in_drain();
    exp_t e;
    bit   ok;
    do_reset();
    run_to_drain(3'b001, ok);
    checks++; if (!ok) begin failures++; $display("FAIL rd_reach_drain got=0 exp=1"); end
    drive(1'b1, '0, 3'b001);
    e = sb.pop_front();
    checks++; if (yumi_seen !== 3'b000) begin failures++; $display("FAIL rd_yumi_in_reset got=%b exp=000", yumi_seen); end
    checks++; if (pipe_stall_o !== 1'b0) begin failures++; $display("FAIL rd_stall got=%b exp=0", pipe_stall_o); end
    checks++; if (wb_pkt_o[W-1] !== 1'b0) begin failures++; $display("FAIL rd_wb_v got=%b exp=0", wb_pkt_o[W-1]); end
    drive(1'b0, '0, 3'b011);
    e = sb.pop_front();
    checks++; if (yumi_seen !== 3'b001) begin failures++; $display("FAIL rd_first_grant got=%b exp=001", yumi_seen); end
    checks++; if (wb_pkt_o !== mk(1'b1, 1'b0, 5'd1, 64'h100) || wb_pkt_o !== e.pkt) begin failures++; $display("FAIL rd_first_wb got=%h exp=%h", wb_pkt_o, e.pkt); end
  endtask

  task automatic test_drop_in_drain();
    exp_t e;
    bit   ok;
    do_reset();
    run_to_drain(3'b100, ok);
    checks++; if (!ok) begin failures++; $display("FAIL dd_reach_drain got=0 exp=1"); end
    drive(1'b0, '0, 3'b000);
    e = sb.pop_front();
    checks++; if (yumi_seen !== 3'b000) begin failures++; $display("FAIL dd_yumi got=%b exp=000", yumi_seen); end
    checks++; if (pipe_stall_o !== 1'b0 || pipe_stall_o !== e.stall) begin failures++; $display("FAIL dd_stall got=%b exp=0", pipe_stall_o); end
    checks++; if (wb_pkt_o !== '0) begin failures++; $display("FAIL dd_wb got=%h exp=0", wb_pkt_o); end
    drive(1'b0, '0, 3'b010);
    e = sb.pop_front();
    checks++; if (yumi_seen !== 3'b010) begin failures++; $display("FAIL dd_regrant got=%b exp=010", yumi_seen); end
    checks++; if (wb_pkt_o !== e.pkt) begin failures++; $display("FAIL dd_regrant_wb got=%h exp=%h", wb_pkt_o, e.pkt); end
  endtask

  initial begin
    reset_i       = 1'b1;
    pipe_wb_pkt_i = '0;
    ll_v_i        = '0;
    for (int i = 0; i < N; i++) ll_pkt_i[i*W +: W] = mk(1'b1, 1'b0, 5'(i + 1), 64'h100 + 64'(i));
    m_ptr = 0; m_cnt = 0; m_drain = 1'b0; m_stats = 0;

    test_reset();
    test_pipe_priority();
    test_round_robin();
    test_starve();
    test_x0_filter();
    test_reset_in_drain();
    test_drop_in_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
